step_run_ctrl: RTL

- Upstream execution controller for the simple processor top level.
- Conditions the raw active-low pushbutton (synchroniser plus debounce) and arbitrates between single-step, free-run and halted modes.
- Produces a one-cycle processor step enable and, one cycle later, a strobe for the LED/HEX display capture registers, so the displays show post-step values.
- Counts executed steps for debug display.

---
 rtl/step_run_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/step_run_ctrl.sv
// Step/run execution controller: conditions the step pushbutton, arbitrates
// single-step / free-run / halt, and issues step and display-latch strobes.
//
// state  | meaning
// IDLE   | waiting for a debounced press or a run request
// STEP   | single step issued this cycle
// RUN    | free-running, one step every RUN_DIV cycles
// HALTED | processor requested halt; only reset leaves
module step_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 25000000,
  parameter int CNT_W           = 25
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        key_n,
  input  logic        run_sw,
  input  logic        halt,
  output logic        step_en,
  output logic        latch_en,
  output logic [1:0]  mode,
  output logic [15:0] step_count
);

  if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (RUN_DIV < 2) begin : g_chk_div
    $error("RUN_DIV must be at least 2");
  end
  if ((longint'(DEBOUNCE_CYCLES) - 1) >= (longint'(1) << CNT_W) ||
      (longint'(RUN_DIV) - 1) >= (longint'(1) << CNT_W)) begin : g_chk_w
    $error("CNT_W too narrow for DEBOUNCE_CYCLES or RUN_DIV");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STEP   = 2'b01,
    RUN    = 2'b10,
    HALTED = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(RUN_DIV - 1);

  state_t           state;
  state_t           state_nxt;
  logic             key_s1;
  logic             ks;
  logic             key_db;
  logic             key_db_q;
  logic             run_s1;
  logic             run_s;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] rate_cnt;
  logic             press;
  logic             rate_tc;
  logic             step_nxt;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_s1 <= 1'b1;
      ks     <= 1'b1;
      run_s1 <= 1'b0;
      run_s  <= 1'b0;
    end else begin
      key_s1 <= key_n;
      ks     <= key_s1;
      run_s1 <= run_sw;
      run_s  <= run_s1;
    end
  end

  // Any sample agreeing with the debounced level restarts the stability count.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      db_cnt   <= '0;
      key_db   <= 1'b1;
      key_db_q <= 1'b1;
    end else begin
      key_db_q <= key_db;
      if (ks == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_db <= ks;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  assign press = key_db_q & ~key_db;

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (halt)       state_nxt = HALTED;
        else if (run_s) state_nxt = RUN;
        else if (press) state_nxt = STEP;
      end
      STEP: begin
        if (halt)       state_nxt = HALTED;
        else if (run_s) state_nxt = RUN;
        else            state_nxt = IDLE;
      end
      RUN: begin
        if (halt)        state_nxt = HALTED;
        else if (!run_s) state_nxt = IDLE;
      end
      default: state_nxt = HALTED;
    endcase
  end

  // A terminal count only fires a step if RUN is held through that cycle.
  assign rate_tc  = (state == RUN) && (rate_cnt == RATE_LAST);
  assign step_nxt = (state_nxt == STEP) || (rate_tc && (state_nxt == RUN));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rate_cnt <= '0;
    end else if (state == RUN && state_nxt == RUN) begin
      rate_cnt <= rate_tc ? '0 : rate_cnt + CNT_W'(1);
    end else begin
      rate_cnt <= '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      step_en    <= 1'b0;
      latch_en   <= 1'b0;
      step_count <= 16'h0000;
    end else begin
      step_en    <= step_nxt;
      latch_en   <= step_en;
      step_count <= step_count + {15'd0, step_en};
    end
  end

  assign mode = state;

endmodule
